mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter_rr_picker.sv | 35 +++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory arbiter.
//   state_t        : arbiter FSM state (IDLE -> ISSUE -> WAIT -> RESP -> IDLE)
//   port_idx_width : bits needed to hold a requester index
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int port_idx_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
//   Requester side : REQ, WE, ADDR, WDATA, BE (flattened, port i at slice i)
//                    ACK (one-hot pulse), RDATA, BUSY
//   Memory side    : MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE, MEM_RDATA
//
// Handshake: REQ[i] acts as a valid that must stay high, with its WE/ADDR/
// WDATA/BE stable, until the single-cycle ACK[i] that completes it. ACK is
// the only "ready"; the ACK cycle consumes the request, and REQ[i] still high
// in the following cycle is a fresh request. Dropping REQ early is illegal.
//
// Modports: slave = the arbiter's view, master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int Ports     = 3,
  parameter int AddrWidth = 16,
  parameter int DataWidth = 32
);

  logic [Ports-1:0]               REQ;
  logic [Ports-1:0]               WE;
  logic [Ports*AddrWidth-1:0]     ADDR;
  logic [Ports*DataWidth-1:0]     WDATA;
  logic [Ports*DataWidth/8-1:0]   BE;
  logic [Ports-1:0]               ACK;
  logic [DataWidth-1:0]           RDATA;
  logic                           BUSY;

  logic                           MEM_EN;
  logic                           MEM_WE;
  logic [AddrWidth-1:0]           MEM_ADDR;
  logic [DataWidth-1:0]           MEM_WDATA;
  logic [DataWidth/8-1:0]         MEM_BE;
  logic [DataWidth-1:0]           MEM_RDATA;

  modport slave (
    input  REQ, WE, ADDR, WDATA, BE, MEM_RDATA,
    output ACK, RDATA, BUSY, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
  );

  modport master (
    output REQ, WE, ADDR, WDATA, BE, MEM_RDATA,
    input  ACK, RDATA, BUSY, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin search over the round-robin requesters
// 1..Ports-1. The search starts at the port after ptr and wraps from
// Ports-1 back to 1; port 0 is not part of the ring.
//   req   : requests of ports 1..Ports-1
//   ptr   : last round-robin winner (1..Ports-1)
//   idx   : first requesting port after ptr (valid when found)
//   found : at least one round-robin port is requesting
module rr_picker #(
  parameter int Ports    = 3,
  parameter int IdxWidth = 2
) (
  input  logic [Ports-1:1]    req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [IdxWidth-1:0] idx,
  output logic                found
);

  // k-th port after p inside the ring 1..Ports-1.
  function automatic logic [IdxWidth-1:0] ring_port(input logic [IdxWidth-1:0] p,
                                                    input int k);
    return IdxWidth'(((int'(p) - 1 + k) % (Ports - 1)) + 1);
  endfunction

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k < Ports; k++) begin
      if (!found && req[ring_port(ptr, k)]) begin
        found = 1'b1;
        idx   = ring_port(ptr, k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Non-pipelined arbiter sharing one single-ported synchronous memory
// between Ports requesters. Port 0 (video scan-out) has fixed priority,
// limited to MaxBurst consecutive grants while another port waits; ports
// 1..Ports-1 are served round-robin. One transaction is in flight at a time.
//   CLK, RST   : clock, synchronous active-high reset
//   bus        : requester and memory signals (see mem_arbiter_if)
//   dbg_state  : current FSM state
//   dbg_rr_ptr : last round-robin winner
//   dbg_burst  : consecutive port-0 grants taken while others waited
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int Ports     = 3,
  parameter int AddrWidth = 16,
  parameter int DataWidth = 32,
  parameter int Latency   = 1,
  parameter int MaxBurst  = 4
) (
  input  logic                               CLK,
  input  logic                               RST,
  mem_arbiter_if.slave                       bus,
  output state_t                             dbg_state,
  output logic [port_idx_width(Ports)-1:0]   dbg_rr_ptr,
  output logic [$clog2(MaxBurst+1)-1:0]      dbg_burst
);

  localparam int IW  = port_idx_width(Ports);
  localparam int BW  = $clog2(MaxBurst + 1);
  localparam int LW  = $clog2(Latency + 1);
  localparam int BEW = DataWidth / 8;

  state_t                state_q;
  logic [IW-1:0]         winner_q;
  logic [LW-1:0]         lat_cnt_q;
  logic [IW-1:0]         rr_ptr_q;
  logic [BW-1:0]         burst_q;
  logic [Ports-1:0]      ack_q;
  logic                  busy_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [AddrWidth-1:0]  mem_addr_q;
  logic [DataWidth-1:0]  mem_wdata_q;
  logic [BEW-1:0]        mem_be_q;

  // Arbitration (only acted on in IDLE).
  logic                  others;
  logic                  p0_wins;
  logic                  rr_found;
  logic [IW-1:0]         rr_idx;
  logic                  grant_valid;
  logic [IW-1:0]         grant_idx;

  logic                  sel_we;
  logic [AddrWidth-1:0]  sel_addr;
  logic [DataWidth-1:0]  sel_wdata;
  logic [BEW-1:0]        sel_be;

  rr_picker #(
    .Ports    (Ports),
    .IdxWidth (IW)
  ) u_rr_picker (
    .req   (bus.REQ[Ports-1:1]),
    .ptr   (rr_ptr_q),
    .idx   (rr_idx),
    .found (rr_found)
  );

  assign others      = |bus.REQ[Ports-1:1];
  // Port 0 loses its priority only once it has used up its burst while
  // someone else is waiting.
  assign p0_wins     = bus.REQ[0] && !(others && (burst_q == BW'(MaxBurst)));
  assign grant_valid = p0_wins || rr_found;
  assign grant_idx   = p0_wins ? '0 : rr_idx;

  always_comb begin
    sel_we    = bus.WE[grant_idx];
    sel_addr  = bus.ADDR[int'(grant_idx) * AddrWidth +: AddrWidth];
    sel_wdata = bus.WDATA[int'(grant_idx) * DataWidth +: DataWidth];
    sel_be    = bus.BE[int'(grant_idx) * BEW +: BEW];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      lat_cnt_q   <= '0;
      rr_ptr_q    <= IW'(Ports - 1);
      burst_q     <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      // Strobes are single-cycle; address/data/byte enables hold.
      ack_q    <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            // The memory fields are loaded here so they are already on
            // MEM_* during the ISSUE cycle.
            winner_q    <= grant_idx;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_be_q    <= sel_be;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
            if (p0_wins) begin
              if (!others) begin
                burst_q <= '0;
              end else if (burst_q != BW'(MaxBurst)) begin
                burst_q <= burst_q + BW'(1);
              end
            end else begin
              rr_ptr_q <= rr_idx;
              burst_q  <= '0;
            end
          end
        end
        ISSUE: begin
          lat_cnt_q <= LW'(Latency - 1);
          if (Latency == 1) begin
            state_q <= RESP;
            ack_q   <= Ports'(1) << winner_q;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Counter was loaded with Latency-1, so WAIT lasts Latency-1 cycles.
          lat_cnt_q <= lat_cnt_q - LW'(1);
          if (lat_cnt_q == LW'(1)) begin
            state_q <= RESP;
            ack_q   <= Ports'(1) << winner_q;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ACK       = ack_q;
  assign bus.BUSY      = busy_q;
  assign bus.MEM_EN    = mem_en_q;
  assign bus.MEM_WE    = mem_we_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WDATA = mem_wdata_q;
  assign bus.MEM_BE    = mem_be_q;
  // A synchronous memory presents its read word in the cycle after its
  // strobe edge, which is the RESP cycle; forwarding it (gated to RESP) puts
  // the data in the same cycle as ACK and keeps RDATA at zero otherwise.
  assign bus.RDATA     = (state_q == RESP) ? bus.MEM_RDATA : '0;

  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;
  assign dbg_burst  = burst_q;

  // At most one completion per cycle.
  assert property (@(posedge CLK) disable iff (RST) $onehot0(bus.ACK));

  // A request that was pending (high, not acknowledged) must still be held.
  assert property (@(posedge CLK) disable iff (RST)
    !$past(RST) |-> (($past(bus.REQ) & ~$past(bus.ACK) & ~bus.REQ) == '0));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUTs: Latency=1 and Latency=3 ----------------
  mem_arbiter_if #(.Ports(3), .AddrWidth(16), .DataWidth(32)) bus1 ();
  mem_arbiter_if #(.Ports(3), .AddrWidth(16), .DataWidth(32)) bus3 ();

  state_t      st1, st3;
  logic [1:0]  ptr1, ptr3;
  logic [2:0]  burst1, burst3;

  mem_arbiter #(.Ports(3), .AddrWidth(16), .DataWidth(32), .Latency(1), .MaxBurst(4)) u_l1 (
    .CLK(CLK), .RST(RST), .bus(bus1),
    .dbg_state(st1), .dbg_rr_ptr(ptr1), .dbg_burst(burst1)
  );

  mem_arbiter #(.Ports(3), .AddrWidth(16), .DataWidth(32), .Latency(3), .MaxBurst(4)) u_l3 (
    .CLK(CLK), .RST(RST), .bus(bus3),
    .dbg_state(st3), .dbg_rr_ptr(ptr3), .dbg_burst(burst3)
  );

  // ---------------- memory stand-ins ----------------
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] rd1 = '0;
  logic [31:0] r3a = '0, r3b = '0, r3c = '0;

  always @(posedge CLK) begin
    if (bus1.MEM_EN) begin
      if (bus1.MEM_WE) begin
        for (int b = 0; b < 4; b++)
          if (bus1.MEM_BE[b]) mem1[bus1.MEM_ADDR[7:0]][8*b +: 8] <= bus1.MEM_WDATA[8*b +: 8];
      end else begin
        rd1 <= mem1[bus1.MEM_ADDR[7:0]];
      end
    end
  end
  assign bus1.MEM_RDATA = rd1;

  always @(posedge CLK) begin
    if (bus3.MEM_EN && !bus3.MEM_WE) r3a <= mem3[bus3.MEM_ADDR[7:0]];
    r3b <= r3a;
    r3c <= r3b;
  end
  assign bus3.MEM_RDATA = r3c;

  // ---------------- grant capture ----------------
  int got_port[$];
  int got_cyc[$];
  int got_burst[$];

  task automatic clear_inputs();
    bus1.REQ = '0; bus1.WE = '0; bus1.ADDR = '0; bus1.WDATA = '0; bus1.BE = '0;
    bus3.REQ = '0; bus3.WE = '0; bus3.ADDR = '0; bus3.WDATA = '0; bus3.BE = '0;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    clear_inputs();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Records ACKs of the Latency=1 DUT; returns at the negedge of the n-th ACK.
  task automatic collect(input int n, input int budget);
    got_port.delete(); got_cyc.delete(); got_burst.delete();
    for (int c = 0; c < budget && got_port.size() < n; c++) begin
      @(negedge CLK);
      if (bus1.ACK != 3'b000) begin
        got_port.push_back($clog2(bus1.ACK));
        got_cyc.push_back(cyc);
        got_burst.push_back(int'(burst1));
      end
    end
    checks++;
    if (got_port.size() != n) begin
      failures++;
      $display("FAIL collect_timeout got=%0d acks exp=%0d", got_port.size(), n);
    end
  endtask

  // Called at a negedge; withdraws each request once it is acknowledged.
  task automatic drain1();
    logic [2:0] a;
    int budget;
    a = bus1.ACK;
    budget = 40;
    forever begin
      @(posedge CLK); #1;
      bus1.REQ = bus1.REQ & ~a;
      if (bus1.REQ == 3'b000) break;
      budget--;
      if (budget == 0) begin
        checks++; failures++;
        $display("FAIL drain_timeout req=%b", bus1.REQ);
        bus1.REQ = '0;
        break;
      end
      @(negedge CLK);
      a = bus1.ACK;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus1.ACK !== 3'b000 || bus3.ACK !== 3'b000) begin failures++; $display("FAIL reset_ack got=%b/%b exp=000", bus1.ACK, bus3.ACK); end
    checks++; if (bus1.RDATA !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus1.RDATA); end
    checks++; if ({bus1.BUSY, bus1.MEM_EN, bus1.MEM_WE} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {bus1.BUSY, bus1.MEM_EN, bus1.MEM_WE}); end
    checks++; if ({bus1.MEM_ADDR, bus1.MEM_WDATA, bus1.MEM_BE} !== 52'h0) begin failures++; $display("FAIL reset_mem_fields got=%h exp=0", {bus1.MEM_ADDR, bus1.MEM_WDATA, bus1.MEM_BE}); end
    checks++; if (st1 !== IDLE || st3 !== IDLE) begin failures++; $display("FAIL reset_state got=%0d/%0d exp=0", st1, st3); end
    checks++; if (ptr1 !== 2'd2) begin failures++; $display("FAIL reset_rr_ptr got=%0d exp=2", ptr1); end
    checks++; if (burst1 !== 3'd0) begin failures++; $display("FAIL reset_burst got=%0d exp=0", burst1); end
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  task automatic test_single_read();
    bus1.REQ = 3'b100; bus1.WE = 3'b000; bus1.ADDR[32 +: 16] = 16'h0010;
    @(negedge CLK); // cycle T
    checks++; if (bus1.MEM_EN !== 1'b0 || bus1.BUSY !== 1'b0) begin failures++; $display("FAIL read_t0 en/busy got=%b%b exp=00", bus1.MEM_EN, bus1.BUSY); end
    @(negedge CLK); // T+1
    checks++; if ({bus1.MEM_EN, bus1.MEM_WE, bus1.BUSY} !== 3'b101) begin failures++; $display("FAIL read_issue en/we/busy got=%b exp=101", {bus1.MEM_EN, bus1.MEM_WE, bus1.BUSY}); end
    checks++; if (bus1.MEM_ADDR !== 16'h0010) begin failures++; $display("FAIL read_issue_addr got=%h exp=0010", bus1.MEM_ADDR); end
    checks++; if (bus1.ACK !== 3'b000) begin failures++; $display("FAIL read_issue_ack got=%b exp=000", bus1.ACK); end
    @(negedge CLK); // T+2
    checks++; if (bus1.ACK !== 3'b100) begin failures++; $display("FAIL read_ack got=%b exp=100", bus1.ACK); end
    checks++; if (bus1.RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL read_rdata got=%h exp=deadbeef", bus1.RDATA); end
    checks++; if (bus1.BUSY !== 1'b1 || bus1.MEM_EN !== 1'b0) begin failures++; $display("FAIL read_resp busy/en got=%b%b exp=10", bus1.BUSY, bus1.MEM_EN); end
    @(posedge CLK); #1 bus1.REQ = 3'b000;
    @(negedge CLK); // T+3
    checks++; if (bus1.BUSY !== 1'b0 || bus1.ACK !== 3'b000) begin failures++; $display("FAIL read_after busy/ack got=%b/%b exp=0/000", bus1.BUSY, bus1.ACK); end
  endtask

  task automatic test_back_to_back();
    @(posedge CLK); #1;
    bus1.REQ = 3'b010; bus1.WE = 3'b010; bus1.ADDR[16 +: 16] = 16'h0020;
    bus1.WDATA[32 +: 32] = 32'h12345678; bus1.BE[4 +: 4] = 4'b0011;
    @(negedge CLK); // T
    @(negedge CLK); // T+1: write strobe
    checks++; if ({bus1.MEM_EN, bus1.MEM_WE} !== 2'b11) begin failures++; $display("FAIL write_issue en/we got=%b exp=11", {bus1.MEM_EN, bus1.MEM_WE}); end
    checks++; if ({bus1.MEM_ADDR, bus1.MEM_WDATA, bus1.MEM_BE} !== {16'h0020, 32'h12345678, 4'b0011}) begin failures++; $display("FAIL write_issue_fields got=%h exp=%h", {bus1.MEM_ADDR, bus1.MEM_WDATA, bus1.MEM_BE}, {16'h0020, 32'h12345678, 4'b0011}); end
    @(negedge CLK); // T+2
    checks++; if (bus1.ACK !== 3'b010 || bus1.MEM_WE !== 1'b0) begin failures++; $display("FAIL write_ack ack/we got=%b/%b exp=010/0", bus1.ACK, bus1.MEM_WE); end
    @(posedge CLK); #1 bus1.WE = 3'b000; // T+3: fresh read request, REQ kept high
    @(negedge CLK);
    @(negedge CLK); // T+4: read strobe
    checks++; if ({bus1.MEM_EN, bus1.MEM_WE} !== 2'b10) begin failures++; $display("FAIL reread_issue en/we got=%b exp=10", {bus1.MEM_EN, bus1.MEM_WE}); end
    @(negedge CLK); // T+5
    checks++; if (bus1.ACK !== 3'b010 || bus1.RDATA !== 32'h00005678) begin failures++; $display("FAIL reread ack/rdata got=%b/%h exp=010/00005678", bus1.ACK, bus1.RDATA); end
    @(posedge CLK); #1 bus1.REQ = 3'b000;
  endtask

  task automatic test_round_robin();
    int exp_p[4] = '{1, 2, 1, 2};
    apply_reset();
    bus1.REQ = 3'b110; bus1.WE = 3'b000;
    bus1.ADDR[16 +: 16] = 16'h0010; bus1.ADDR[32 +: 16] = 16'h0010;
    collect(4, 40);
    for (int i = 0; i < got_port.size(); i++) begin
      checks++; if (got_port[i] != exp_p[i]) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, got_port[i], exp_p[i]); end
      if (i > 0) begin
        checks++; if (got_cyc[i] - got_cyc[i-1] != 3) begin failures++; $display("FAIL rr_spacing[%0d] got=%0d exp=3", i, got_cyc[i] - got_cyc[i-1]); end
      end
    end
    drain1();
  endtask

  task automatic test_starvation();
    int exp_p[10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
    int exp_b[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    @(posedge CLK); #1;
    bus1.REQ = 3'b101; bus1.WE = 3'b000;
    bus1.ADDR[0 +: 16] = 16'h0020; bus1.ADDR[32 +: 16] = 16'h0010;
    collect(10, 100);
    for (int i = 0; i < got_port.size(); i++) begin
      checks++; if (got_port[i] != exp_p[i]) begin failures++; $display("FAIL starve_order[%0d] got=%0d exp=%0d", i, got_port[i], exp_p[i]); end
      checks++; if (got_burst[i] != exp_b[i]) begin failures++; $display("FAIL starve_burst[%0d] got=%0d exp=%0d", i, got_burst[i], exp_b[i]); end
    end
    drain1();
  endtask

  task automatic test_latency3();
    logic [2:0] exp_ack;
    @(posedge CLK); #1;
    bus3.REQ = 3'b010; bus3.WE = 3'b000; bus3.ADDR[16 +: 16] = 16'h0010;
    for (int c = 0; c <= 4; c++) begin
      @(negedge CLK); // cycle T+c
      exp_ack = (c == 4) ? 3'b010 : 3'b000;
      checks++; if (bus3.ACK !== exp_ack) begin failures++; $display("FAIL lat3_ack[T+%0d] got=%b exp=%b", c, bus3.ACK, exp_ack); end
      checks++; if (bus3.MEM_EN !== (c == 1)) begin failures++; $display("FAIL lat3_en[T+%0d] got=%b exp=%b", c, bus3.MEM_EN, (c == 1)); end
    end
    checks++; if (bus3.RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL lat3_rdata got=%h exp=deadbeef", bus3.RDATA); end
    @(posedge CLK); #1 bus3.REQ = 3'b000;
  endtask

  task automatic test_reset_mid_wait();
    logic [2:0] exp_ack;
    @(posedge CLK); #1;
    bus3.REQ = 3'b010; bus3.WE = 3'b000; bus3.ADDR[16 +: 16] = 16'h0010;
    @(negedge CLK); // T
    @(negedge CLK); // T+1 ISSUE
    @(posedge CLK); #1; // T+2
    RST = 1'b1; bus3.REQ = 3'b000;
    @(negedge CLK);
    checks++; if (st3 !== WAIT) begin failures++; $display("FAIL abort_pre_state got=%0d exp=%0d", st3, WAIT); end
    @(posedge CLK); #1 RST = 1'b0; // T+3
    @(negedge CLK);
    checks++; if (st3 !== IDLE || bus3.BUSY !== 1'b0 || bus3.MEM_EN !== 1'b0) begin failures++; $display("FAIL abort_idle state/busy/en got=%0d/%b/%b exp=0/0/0", st3, bus3.BUSY, bus3.MEM_EN); end
    checks++; if (ptr3 !== 2'd2) begin failures++; $display("FAIL abort_ptr got=%0d exp=2", ptr3); end
    @(negedge CLK); // T+4, where the aborted ACK would have been
    checks++; if (bus3.ACK !== 3'b000) begin failures++; $display("FAIL abort_no_ack got=%b exp=000", bus3.ACK); end
    @(posedge CLK); #1;
    bus3.REQ = 3'b010; bus3.ADDR[16 +: 16] = 16'h0030;
    for (int c = 0; c <= 4; c++) begin
      @(negedge CLK);
      exp_ack = (c == 4) ? 3'b010 : 3'b000;
      checks++; if (bus3.ACK !== exp_ack) begin failures++; $display("FAIL post_abort_ack[T+%0d] got=%b exp=%b", c, bus3.ACK, exp_ack); end
    end
    checks++; if (bus3.RDATA !== 32'hA5A50F0F || ptr3 !== 2'd1) begin failures++; $display("FAIL post_abort rdata/ptr got=%h/%0d exp=a5a50f0f/1", bus3.RDATA, ptr3); end
    @(posedge CLK); #1 bus3.REQ = 3'b000;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    mem1[8'h10] = 32'hDEADBEEF;
    mem3[8'h10] = 32'hDEADBEEF;
    mem3[8'h30] = 32'hA5A50F0F;
    clear_inputs();

    test_reset();
    test_single_read();
    test_back_to_back();
    test_round_robin();
    test_starvation();
    test_latency3();
    test_reset_mid_wait();

    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
